// File: rtl/geri_yaz_hakemi.sv
// Register-file write-port arbiter for pipeline, load-return and divider/FP results.
// A starvation counter lifts a long-waiting load or divider result above the pipeline.
module geri_yaz_hakemi #(
    parameter int VERI_BIT     = 32,
    parameter int BEKLEME_ESIK = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                yurut_gecerli_i,
    input  logic [4:0]          yurut_adres_i,
    input  logic [VERI_BIT-1:0] yurut_veri_i,
    input  logic                yurut_fp_i,
    output logic                yurut_hazir_o,
    input  logic                bel_gecerli_i,
    input  logic [4:0]          bel_adres_i,
    input  logic [VERI_BIT-1:0] bel_veri_i,
    input  logic                bel_fp_i,
    output logic                bel_hazir_o,
    input  logic                bol_gecerli_i,
    input  logic [4:0]          bol_adres_i,
    input  logic [VERI_BIT-1:0] bol_veri_i,
    input  logic                bol_fp_i,
    output logic                bol_hazir_o,
    input  logic                bh_bosalt_i,
    output logic                yazmac_yaz_o,
    output logic                os_yaz_o,
    output logic [4:0]          yazmac_adres_o,
    output logic [VERI_BIT-1:0] yazmac_yaz_veri_o
);

    localparam int SW = $clog2(BEKLEME_ESIK + 1);
    localparam logic [SW-1:0] ESIK = SW'(BEKLEME_ESIK);

    logic [SW-1:0]       bel_sayac_q, bel_sayac_d;
    logic [SW-1:0]       bol_sayac_q, bol_sayac_d;
    logic                yaz_q, yaz_d;
    logic                os_q, os_d;
    logic [4:0]          adres_q, adres_d;
    logic [VERI_BIT-1:0] veri_q, veri_d;

    logic yurut_ister, bel_ac, bol_ac;
    logic g_yurut, g_bel, g_bol;
    logic sec_fp;
    logic [4:0] sec_adres;
    logic [VERI_BIT-1:0] sec_veri;

    always_comb begin
        yurut_ister = yurut_gecerli_i & ~bh_bosalt_i;
        bel_ac      = bel_gecerli_i & (bel_sayac_q == ESIK);
        bol_ac      = bol_gecerli_i & (bol_sayac_q == ESIK);
        g_yurut     = 1'b0;
        g_bel       = 1'b0;
        g_bol       = 1'b0;
        priority case (1'b1)
            bel_ac:        g_bel   = 1'b1;
            bol_ac:        g_bol   = 1'b1;
            yurut_ister:   g_yurut = 1'b1;
            bel_gecerli_i: g_bel   = 1'b1;
            bol_gecerli_i: g_bol   = 1'b1;
            default: ;
        endcase
    end

    // A flushed pipeline result is swallowed without taking the write port.
    assign yurut_hazir_o = bh_bosalt_i ? yurut_gecerli_i : g_yurut;
    assign bel_hazir_o   = g_bel;
    assign bol_hazir_o   = g_bol;

    function automatic logic [SW-1:0] sayac_sonraki(
        input logic [SW-1:0] q,
        input logic          gecerli,
        input logic          verildi
    );
        if (!gecerli || verildi)
            return '0;
        if (q == ESIK)
            return q;
        return q + SW'(1);
    endfunction

    always_comb begin
        bel_sayac_d = sayac_sonraki(bel_sayac_q, bel_gecerli_i, g_bel);
        bol_sayac_d = sayac_sonraki(bol_sayac_q, bol_gecerli_i, g_bol);
    end

    always_comb begin
        sec_fp    = yurut_fp_i;
        sec_adres = yurut_adres_i;
        sec_veri  = yurut_veri_i;
        if (g_bel) begin
            sec_fp    = bel_fp_i;
            sec_adres = bel_adres_i;
            sec_veri  = bel_veri_i;
        end else if (g_bol) begin
            sec_fp    = bol_fp_i;
            sec_adres = bol_adres_i;
            sec_veri  = bol_veri_i;
        end
    end

    always_comb begin
        yaz_d   = 1'b0;
        os_d    = 1'b0;
        adres_d = adres_q;
        veri_d  = veri_q;
        if (g_yurut | g_bel | g_bol) begin
            yaz_d   = ~sec_fp & (sec_adres != 5'd0);
            os_d    = sec_fp;
            adres_d = sec_adres;
            veri_d  = sec_veri;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bel_sayac_q <= '0;
            bol_sayac_q <= '0;
            yaz_q       <= 1'b0;
            os_q        <= 1'b0;
            adres_q     <= '0;
            veri_q      <= '0;
        end else begin
            bel_sayac_q <= bel_sayac_d;
            bol_sayac_q <= bol_sayac_d;
            yaz_q       <= yaz_d;
            os_q        <= os_d;
            adres_q     <= adres_d;
            veri_q      <= veri_d;
        end
    end

    assign yazmac_yaz_o      = yaz_q;
    assign os_yaz_o          = os_q;
    assign yazmac_adres_o    = adres_q;
    assign yazmac_yaz_veri_o = veri_q;

endmodule

// File: tb/tb_geri_yaz_hakemi.sv
// Self-checking bench for geri_yaz_hakemi: directed scenarios then random traffic
// compared against a priority-list reference model.
module tb_geri_yaz_hakemi;

    localparam int ESIK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic yv = 0, bv = 0, ov = 0, fl = 0;
    logic [4:0] ya = 0, ba = 0, oa = 0;
    logic [31:0] yd = 0, bd = 0, od = 0;
    logic yf = 0, bf = 0, of_ = 0;
    logic yh, bh, oh, yaz, os;
    logic [4:0] adr;
    logic [31:0] veri;

    int nvec = 0;
    int nerr = 0;
    int cb = 0, co = 0;
    int last_w = -1;
    bit e_yaz = 0, e_os = 0;
    bit [4:0] e_adr = 0;
    bit [31:0] e_veri = 0;
    bit y_acc, b_acc, o_acc;

    always #5 clk = ~clk;

    geri_yaz_hakemi #(.VERI_BIT(32), .BEKLEME_ESIK(ESIK)) dut (
        .clk_i(clk), .rst_i(rst),
        .yurut_gecerli_i(yv), .yurut_adres_i(ya), .yurut_veri_i(yd),
        .yurut_fp_i(yf), .yurut_hazir_o(yh),
        .bel_gecerli_i(bv), .bel_adres_i(ba), .bel_veri_i(bd),
        .bel_fp_i(bf), .bel_hazir_o(bh),
        .bol_gecerli_i(ov), .bol_adres_i(oa), .bol_veri_i(od),
        .bol_fp_i(of_), .bol_hazir_o(oh),
        .bh_bosalt_i(fl),
        .yazmac_yaz_o(yaz), .os_yaz_o(os),
        .yazmac_adres_o(adr), .yazmac_yaz_veri_o(veri)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out();
        chk("yazmac_yaz", 64'(yaz), 64'(e_yaz));
        chk("os_yaz", 64'(os), 64'(e_os));
        chk("adres", 64'(adr), 64'(e_adr));
        chk("veri", 64'(veri), 64'(e_veri));
    endtask

    function automatic void load(input bit [4:0] a, input bit [31:0] d, input bit f);
        e_yaz  = !f && (a != 0);
        e_os   = f;
        e_adr  = a;
        e_veri = d;
    endfunction

    function automatic int bump(input int c, input bit v, input bit g);
        if (!v || g) return 0;
        return (c < ESIK) ? c + 1 : ESIK;
    endfunction

    // One full cycle: inputs already driven after a falling edge.
    task automatic tick();
        int w;
        bit yr;
        #1;
        yr = yv && !fl;
        if (bv && cb == ESIK) w = 1;
        else if (ov && co == ESIK) w = 2;
        else if (yr) w = 0;
        else if (bv) w = 1;
        else if (ov) w = 2;
        else w = -1;
        last_w = w;
        chk("yurut_hazir", 64'(yh), 64'(fl ? yv : (w == 0)));
        chk("bel_hazir", 64'(bh), 64'(w == 1));
        chk("bol_hazir", 64'(oh), 64'(w == 2));
        @(posedge clk);
        cb = bump(cb, bv, w == 1);
        co = bump(co, ov, w == 2);
        case (w)
            0: load(ya, yd, yf);
            1: load(ba, bd, bf);
            2: load(oa, od, of_);
            default: begin e_yaz = 0; e_os = 0; end
        endcase
        #1;
        chk_out();
        @(negedge clk);
    endtask

    task automatic idle();
        yv = 0; bv = 0; ov = 0; fl = 0;
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        chk_out();
        rst = 1'b0;

        // T1 single bel request
        bv = 1; ba = 5; bd = 32'hCAFE0001; bf = 0;
        tick();
        idle();
        tick();

        // T2 starvation of bol behind a busy pipeline
        ov = 1; oa = 12; od = 32'h0B0B0000; of_ = 0;
        for (int i = 0; i < 6; i++) begin
            yv = !(last_w == 2 && i > 0) || 1'b1;
            ya = 5'(i + 1); yd = 32'h1000 + i; yf = 0;
            if (i == 5) ov = 0;
            tick();
        end
        idle();
        tick();

        // T3 flush: pipeline result discarded, bol writes
        fl = 1; yv = 1; ya = 7; yd = 32'h77;
        ov = 1; oa = 9; od = 32'h99; of_ = 0;
        tick();
        idle();
        tick();

        // T4 rd=0 integer suppressed, FP f0 written
        yv = 1; ya = 0; yd = 32'hDEAD; yf = 0;
        tick();
        yf = 1; yd = 32'hBEEF;
        tick();
        idle(); yf = 0;
        tick();

        // T5 async reset with a write sitting in the output register
        bv = 1; ba = 3; bd = 32'h3333; bf = 0;
        #1;
        chk("t5_bel_hazir", 64'(bh), 64'd1);
        @(posedge clk);
        #1;
        chk("t5_strobe", 64'(yaz), 64'd1);
        rst = 1'b1;
        #1;
        cb = 0; co = 0; e_yaz = 0; e_os = 0; e_adr = 0; e_veri = 0;
        chk_out();
        idle();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        ov = 1; oa = 14; od = 32'h1414; of_ = 1;
        for (int i = 0; i < 5; i++) begin
            yv = 1; ya = 5'(20 + i); yd = 32'h2000 + i;
            tick();
        end
        idle();
        tick();

        // T6 bel and bol both starving
        bv = 1; ba = 4; bd = 32'h4444; bf = 0;
        ov = 1; oa = 6; od = 32'h6666; of_ = 0;
        for (int i = 0; i < 7; i++) begin
            yv = 1; ya = 5'(10 + i); yd = 32'h6000 + i; yf = 0;
            if (last_w == 1 && i > 0) bv = 0;
            if (last_w == 2 && i > 0) ov = 0;
            tick();
        end
        idle();
        tick();

        // random traffic, requesters hold until accepted
        y_acc = 1; b_acc = 1; o_acc = 1;
        for (int i = 0; i < 400; i++) begin
            if (!yv || y_acc) begin
                yv = $urandom_range(0, 3) != 0;
                ya = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                yd = $urandom; yf = $urandom_range(0, 3) == 0;
            end
            if (!bv || b_acc) begin
                bv = $urandom_range(0, 1) != 0;
                ba = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                bd = $urandom; bf = $urandom_range(0, 3) == 0;
            end
            if (!ov || o_acc) begin
                ov = $urandom_range(0, 1) != 0;
                oa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                od = $urandom; of_ = $urandom_range(0, 3) == 0;
            end
            fl = $urandom_range(0, 7) == 0;
            tick();
            y_acc = fl ? yv : (last_w == 0);
            b_acc = last_w == 1;
            o_acc = last_w == 2;
        end
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
